// File: rtl/elastic_shift_register_with_valid_pkg.sv
// Shared types and helpers for the elastic valid/ready shift register.
// Covers occupancy-counter sizing and update-direction decoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_HOLD = 2'd0,
        OCC_INC  = 2'd1,
        OCC_DEC  = 2'd2
    } occ_op_e;

    typedef struct packed {
        logic in_xfer;
        logic out_xfer;
    } xfer_t;

    function automatic int unsigned cnt_w_of(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic occ_op_e occ_op(input xfer_t x);
        if (x.in_xfer && !x.out_xfer) return OCC_INC;
        if (!x.in_xfer && x.out_xfer) return OCC_DEC;
        return OCC_HOLD;
    endfunction

endpackage

// File: rtl/elastic_shift_register_with_valid_if.sv
// Upstream/downstream handshake bundle plus flush and occupancy.
interface elastic_shift_register_with_valid_if #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 8
);
    localparam int unsigned cnt_w = pipe_pkg::cnt_w_of(depth);

    logic             flush;
    logic             in_vld;
    logic             in_rdy;
    logic [width-1:0] in_data;
    logic             out_vld;
    logic             out_rdy;
    logic [width-1:0] out_data;
    logic [cnt_w-1:0] occupancy;

    modport master (
        output flush, in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, occupancy
    );

    modport slave (
        input  flush, in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, occupancy
    );
endinterface

// File: rtl/elastic_shift_register_with_valid_stage.sv
// One elastic stage: holds an item until the downstream side can take it.
module elastic_stage #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_vld,
    input  logic [width-1:0] up_data,
    input  logic             dn_rdy,
    output logic             vld,
    output logic [width-1:0] data,
    output logic             rdy
);
    logic             vld_d, vld_q;
    logic [width-1:0] data_d, data_q;

    assign rdy  = ~vld_q | dn_rdy;
    assign vld  = vld_q;
    assign data = data_q;

    // Data only loads on a real transfer so bubbles never toggle the data regs.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (rdy) begin
            vld_d = up_vld;
            if (up_vld) data_d = up_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/elastic_shift_register_with_valid.sv
// Chain of depth elastic stages with collapsing bubbles, flush and a
// registered occupancy count.
module elastic_shift_register_with_valid
    import pipe_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 8
) (
    input logic clk,
    input logic rst,
    elastic_shift_register_with_valid_if.slave bus
);
    localparam int unsigned cnt_w = cnt_w_of(depth);

    logic             vld  [depth];
    logic [width-1:0] data [depth];
    logic             rdy  [depth];
    xfer_t            xfer;
    logic [cnt_w-1:0] occ_d, occ_q;

    assign bus.in_rdy    = rdy[0] & ~bus.flush & ~rst;
    assign bus.out_vld   = vld[depth-1];
    assign bus.out_data  = data[depth-1];
    assign bus.occupancy = occ_q;

    assign xfer.in_xfer  = bus.in_vld & bus.in_rdy;
    assign xfer.out_xfer = bus.out_vld & bus.out_rdy;

    for (genvar i = 0; i < depth; i++) begin : g_stage
        logic             up_vld;
        logic [width-1:0] up_data;
        logic             dn_rdy;

        if (i == 0) begin : g_head
            assign up_vld  = xfer.in_xfer;
            assign up_data = bus.in_data;
        end else begin : g_body
            assign up_vld  = vld[i-1];
            assign up_data = data[i-1];
        end

        if (i == depth - 1) begin : g_tail
            assign dn_rdy = bus.out_rdy;
        end else begin : g_mid
            assign dn_rdy = rdy[i+1];
        end

        elastic_stage #(.width(width)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (bus.flush),
            .up_vld  (up_vld),
            .up_data (up_data),
            .dn_rdy  (dn_rdy),
            .vld     (vld[i]),
            .data    (data[i]),
            .rdy     (rdy[i])
        );
    end

    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = '0;
        end else begin
            case (occ_op(xfer))
                OCC_INC:  occ_d = occ_q + 1'b1;
                OCC_DEC:  occ_d = occ_q - 1'b1;
                default:  occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end
endmodule

// File: tb/tb_elastic_shift_register_with_valid.sv
// Bench for the elastic shift register: fixed vector table, directed corner
// sequences and randomized traffic against a queue-of-items reference model.
module tb_elastic_shift_register_with_valid;
    import pipe_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst;

    elastic_shift_register_with_valid_if #(.width(WIDTH), .depth(DEPTH)) bus ();

    elastic_shift_register_with_valid #(.width(WIDTH), .depth(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: in-flight items in arrival order, each with its stage
    // position. An item advances one stage per cycle but can never pass the
    // packed slot reserved for it behind the older items.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               pos;
    } item_t;

    item_t q[$];
    int cyc = 0;
    logic s_in_rdy, s_out_vld, acc;
    logic [WIDTH-1:0] s_out_data;

    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [WIDTH-1:0] d, input logic ordy);
        logic e_vld, e_rdy;
        @(negedge clk);
        rst = r; bus.flush = f; bus.in_vld = iv; bus.in_data = d; bus.out_rdy = ordy;
        #1;
        cyc++;
        e_vld = (q.size() > 0) && (q[0].pos == int'(DEPTH) - 1);
        e_rdy = !r && !f && ((q.size() < int'(DEPTH)) || (e_vld && ordy));
        chk("in_rdy", int'(bus.in_rdy), int'(e_rdy));
        chk("out_vld", int'(bus.out_vld), int'(e_vld));
        chk("occupancy", int'(bus.occupancy), q.size());
        if (e_vld) chk("out_data", int'(bus.out_data), int'(q[0].data));
        s_in_rdy = bus.in_rdy; s_out_vld = bus.out_vld; s_out_data = bus.out_data;
        acc = iv && bus.in_rdy;
        if (r) begin
            q.delete();
        end else begin
            if (e_vld && ordy) void'(q.pop_front());
            if (f) begin
                q.delete();
            end else begin
                for (int k = 0; k < q.size(); k++) begin
                    int lim = int'(DEPTH) - 1 - k;
                    q[k].pos = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim;
                end
                if (iv && e_rdy) q.push_back('{data: d, pos: 0});
            end
        end
    endtask

    typedef struct {
        logic             r, f, iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             e_in_rdy, e_out_vld;
        logic [WIDTH-1:0] e_data;
        logic             chk_data;
        int               e_occ;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_acc, first_out, sent, waited;
        logic [WIDTH-1:0] outs[$];

        // rst, flush, in_vld, in_data, out_rdy | in_rdy, out_vld, out_data, check data, occupancy
        for (int i = 0; i < 3; i++) vecs.push_back('{1, 0, 1, 8'hAA, 0, 0, 0, 8'h00, 1, 0});
        vecs.push_back('{0, 0, 1, 8'h11, 0, 1, 0, 8'h00, 1, 0});
        vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 1});
        vecs.push_back('{0, 0, 1, 8'h22, 0, 1, 0, 8'h00, 1, 1});
        vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 2});
        vecs.push_back('{0, 0, 1, 8'h33, 0, 1, 0, 8'h00, 1, 2});
        for (int i = 0; i < 3; i++) vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 3});
        for (int i = 0; i < 4; i++) vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 1, 8'h11, 1, 3});
        vecs.push_back('{0, 0, 0, 8'h00, 1, 1, 1, 8'h11, 1, 3});
        vecs.push_back('{0, 0, 0, 8'h00, 1, 1, 1, 8'h22, 1, 2});
        vecs.push_back('{0, 0, 0, 8'h00, 1, 1, 1, 8'h33, 1, 1});
        vecs.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0});
        vecs.push_back('{0, 0, 1, 8'h44, 0, 1, 0, 8'h00, 0, 0});
        vecs.push_back('{0, 1, 1, 8'h55, 0, 0, 0, 8'h00, 0, 1});
        vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});

        rst = 1'b1; bus.flush = 1'b0; bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b0;
        @(posedge clk);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            rst = vecs[n].r; bus.flush = vecs[n].f; bus.in_vld = vecs[n].iv;
            bus.in_data = vecs[n].d; bus.out_rdy = vecs[n].ordy;
            #1;
            chk($sformatf("vec%0d_in_rdy", n), int'(bus.in_rdy), int'(vecs[n].e_in_rdy));
            chk($sformatf("vec%0d_out_vld", n), int'(bus.out_vld), int'(vecs[n].e_out_vld));
            chk($sformatf("vec%0d_occ", n), int'(bus.occupancy), vecs[n].e_occ);
            if (vecs[n].chk_data)
                chk($sformatf("vec%0d_out_data", n), int'(bus.out_data), int'(vecs[n].e_data));
        end

        // Latency and full throughput.
        cycle(1, 0, 0, 8'h00, 1);
        cycle(1, 0, 0, 8'h00, 1);
        first_acc = -1; first_out = -1; sent = 0;
        for (int n = 0; n < 40; n++) begin
            cycle(0, 0, sent < 16, 8'(sent + 1), 1);
            if (acc) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            if (s_out_vld) begin
                if (first_out < 0) first_out = cyc;
                outs.push_back(s_out_data);
            end
        end
        chk("stream_latency", first_out - first_acc, int'(DEPTH));
        chk("stream_count", outs.size(), 16);
        for (int i = 0; i < outs.size(); i++) chk("stream_order", int'(outs[i]), i + 1);

        // Full chain, then pass-through while full.
        cycle(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < int'(DEPTH); i++) cycle(0, 0, 1, 8'(8'hC0 + i), 0);
        cycle(0, 0, 1, 8'h99, 0);
        chk("full_in_rdy", int'(s_in_rdy), 0);
        chk("full_occ", int'(bus.occupancy), int'(DEPTH));
        cycle(0, 0, 1, 8'h9A, 1);
        chk("passthru_in_rdy", int'(s_in_rdy), 1);
        chk("passthru_out", int'(s_out_data), 8'hC0);
        cycle(0, 0, 0, 8'h00, 0);
        chk("passthru_occ", int'(bus.occupancy), int'(DEPTH));

        // Flush with items inside, then latency of the first item after it.
        cycle(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(8'h70 + i), 0);
        cycle(0, 1, 1, 8'h77, 0);
        chk("flush_in_rdy", int'(s_in_rdy), 0);
        cycle(0, 0, 0, 8'h00, 0);
        chk("flush_out_vld", int'(s_out_vld), 0);
        chk("flush_occ", int'(bus.occupancy), 0);
        cycle(0, 0, 1, 8'h5A, 1);
        first_acc = acc ? cyc : -100;
        first_out = -1;
        waited = 0;
        while (first_out < 0 && waited < 20) begin
            cycle(0, 0, 0, 8'h00, 1);
            waited++;
            if (s_out_vld) begin
                first_out = cyc;
                chk("post_flush_data", int'(s_out_data), 8'h5A);
            end
        end
        chk("post_flush_latency", first_out - first_acc, int'(DEPTH));

        // Reset mid-stream discards everything.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'(8'hE0 + i), 0);
        cycle(1, 0, 1, 8'hEE, 1);
        chk("midrst_in_rdy", int'(s_in_rdy), 0);
        cycle(0, 0, 0, 8'h00, 0);
        chk("midrst_occ", int'(bus.occupancy), 0);
        chk("midrst_out_data", int'(bus.out_data), 0);

        // Randomized traffic in phases of varying downstream pressure.
        for (int n = 0; n < 10000; n++) begin
            int unsigned phase = (n / 500) % 3;
            logic r  = ($urandom % 1000) == 0;
            logic f  = ($urandom % 150) == 0;
            logic iv = ($urandom % 4) != 0;
            logic od = ($urandom % 4) < (phase + 1);
            cycle(r, f, iv, 8'($urandom), od);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
